// File: rtl/seq_strip.sv
// Receive-side sequence-word stripper: removes the trailing {0, seq} word of each
// frame, moves tlast onto the last payload word and checks sequence continuity.
module seq_strip #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16,
    parameter int SEQ_INIT   = 1
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  ctrl_strip_seq_en,
    output logic [SEQ_WIDTH-1:0]  seq_last,
    output logic                  seq_err,
    output logic [15:0]           seq_err_cnt,
    output logic [15:0]           runt_cnt,
    output logic [31:0]           frame_cnt
);

    localparam logic [SEQ_WIDTH-1:0] SEQ_RST = SEQ_INIT[SEQ_WIDTH-1:0];

    logic                  mode_q;
    logic                  in_frame;
    logic                  held_v;
    logic [DATA_WIDTH-1:0] held_data;
    logic [SEQ_WIDTH-1:0]  expected;

    logic                  accept;
    logic                  seq_word_accept;
    logic [SEQ_WIDTH-1:0]  seq_field;
    logic [DATA_WIDTH-1:0] upper_bits;
    logic                  seq_bad;

    always_comb begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        if (mode_q) begin
            s_axis_tready = !held_v || m_axis_tready;
            m_axis_tvalid = held_v && s_axis_tvalid;
            m_axis_tdata  = held_data;
        end
    end

    // The trailing word of a stripped frame is consumed here and never forwarded.
    always_comb begin
        accept          = s_axis_tvalid && s_axis_tready;
        seq_word_accept = mode_q && accept && s_axis_tlast;
        seq_field       = s_axis_tdata[SEQ_WIDTH-1:0];
        upper_bits      = s_axis_tdata >> SEQ_WIDTH;
        seq_bad         = (seq_field != expected) || (upper_bits != '0);
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            mode_q    <= 1'b1;
            in_frame  <= 1'b0;
            held_v    <= 1'b0;
            held_data <= '0;
        end else begin
            if (accept) begin
                in_frame <= !s_axis_tlast;
            end
            if (mode_q && accept) begin
                held_v <= !s_axis_tlast;
                if (!s_axis_tlast) begin
                    held_data <= s_axis_tdata;
                end
            end
            // Mode only changes on an idle frame boundary so a frame is never split.
            if (!in_frame && !held_v && !accept) begin
                mode_q <= ctrl_strip_seq_en;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            expected    <= SEQ_RST;
            seq_last    <= '0;
            seq_err     <= 1'b0;
            seq_err_cnt <= '0;
            runt_cnt    <= '0;
            frame_cnt   <= '0;
        end else begin
            seq_err <= 1'b0;
            if (seq_word_accept) begin
                seq_last  <= seq_field;
                expected  <= seq_field + 1'b1;
                frame_cnt <= frame_cnt + 32'd1;
                if (seq_bad) begin
                    seq_err <= 1'b1;
                    if (seq_err_cnt != 16'hFFFF) begin
                        seq_err_cnt <= seq_err_cnt + 16'd1;
                    end
                end
                if (!held_v && runt_cnt != 16'hFFFF) begin
                    runt_cnt <= runt_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_strip.sv
// Directed self-checking bench for seq_strip: stripping, sequence checks, runts,
// wrap, backpressure and the frame-boundary mode switch.
module tb_seq_strip;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        ctrl_en;
    logic [15:0] seq_last;
    logic        seq_err;
    logic [15:0] seq_err_cnt;
    logic [15:0] runt_cnt;
    logic [31:0] frame_cnt;

    int checks = 0;
    int fails  = 0;
    int err_pulses = 0;
    int pulse_base = 0;
    int hs_bad = 0;
    int cyc = 0;
    bit toggle_ready = 0;
    bit tb_strip = 1;
    bit tb_held = 0;
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];

    seq_strip #(.DATA_WIDTH(32), .SEQ_WIDTH(16), .SEQ_INIT(1)) dut (
        .m_axis_aclk       (clk),
        .m_axis_aresetn    (rst_n),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tdata      (s_tdata),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tlast      (m_tlast),
        .m_axis_tready     (m_tready),
        .ctrl_strip_seq_en (ctrl_en),
        .seq_last          (seq_last),
        .seq_err           (seq_err),
        .seq_err_cnt       (seq_err_cnt),
        .runt_cnt          (runt_cnt),
        .frame_cnt         (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && seq_err) err_pulses++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready = 1'b1; ctrl_en = 1'b1;
        toggle_ready = 0; tb_strip = 1; tb_held = 0; hs_bad = 0;
        out_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_base = err_pulses;
    endtask

    // One bus cycle: drive at negedge, sample 1ns later, let the posedge transfer.
    task automatic bus_cycle(input logic v, input logic [31:0] d, input logic l, output bit acc);
        logic exp_ready;
        @(negedge clk);
        s_tvalid = v; s_tdata = d; s_tlast = l;
        m_tready = toggle_ready ? cyc[0] : 1'b1;
        cyc++;
        #1;
        exp_ready = tb_strip ? (!tb_held || m_tready) : m_tready;
        if (s_tready !== exp_ready) hs_bad++;
        acc = s_tvalid && s_tready;
        if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
        if (acc && tb_strip) tb_held = !l;
    endtask

    task automatic send_frame(input int npay, input logic [31:0] base, input logic [31:0] seqw,
                              input int switch_at);
        bit acc;
        int tries;
        logic [31:0] w;
        for (int i = 0; i < npay; i++) begin
            if (tb_strip) exp_q.push_back({(i == npay - 1), base + i});
            else          exp_q.push_back({1'b0, base + i});
        end
        if (!tb_strip) exp_q.push_back({1'b1, seqw});
        for (int i = 0; i <= npay; i++) begin
            w = (i < npay) ? base + i : seqw;
            if (i == switch_at) ctrl_en = 1'b0;
            acc = 0; tries = 0;
            while (!acc && tries < 20) begin
                bus_cycle(1'b1, w, (i == npay), acc);
                tries++;
            end
            if (!acc) hs_bad++;
        end
        bus_cycle(1'b0, 32'h0, 1'b0, acc);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (m_tvalid !== 1'b0)   begin fails++; $display("[TB] FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b1)   begin fails++; $display("[TB] FAIL reset_s_tready got %b want 1", s_tready); end
        checks++; if (seq_last !== 16'h0)  begin fails++; $display("[TB] FAIL reset_seq_last got %h want 0", seq_last); end
        checks++; if (seq_err !== 1'b0)    begin fails++; $display("[TB] FAIL reset_seq_err got %b want 0", seq_err); end
        checks++; if (seq_err_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_err_cnt got %0d want 0", seq_err_cnt); end
        checks++; if (runt_cnt !== 16'h0)  begin fails++; $display("[TB] FAIL reset_runt_cnt got %0d want 0", runt_cnt); end
        checks++; if (frame_cnt !== 32'h0) begin fails++; $display("[TB] FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(3, 32'hD000_0000, 32'h0000_0001, -1);
        checks++; if (out_q.size() !== 3) begin fails++; $display("[TB] FAIL basic_beats got %0d want 3", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL basic_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (seq_last !== 16'd1)   begin fails++; $display("[TB] FAIL basic_seq_last got %0d want 1", seq_last); end
        checks++; if (frame_cnt !== 32'd1)  begin fails++; $display("[TB] FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (seq_err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL basic_err_cnt got %0d want 0", seq_err_cnt); end
        checks++; if (hs_bad !== 0) begin fails++; $display("[TB] FAIL basic_handshake got %0d want 0", hs_bad); end
    endtask

    task automatic test_seq_gap();
        logic [15:0] seqs[5] = '{16'd1, 16'd2, 16'd4, 16'd5, 16'd6};
        do_reset();
        foreach (seqs[k]) send_frame(2, 32'hA000_0000 + (k << 8), {16'h0, seqs[k]}, -1);
        checks++; if (out_q.size() !== exp_q.size()) begin fails++; $display("[TB] FAIL gap_beats got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL gap_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (err_pulses - pulse_base !== 1) begin fails++; $display("[TB] FAIL gap_pulses got %0d want 1", err_pulses - pulse_base); end
        checks++; if (seq_err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL gap_err_cnt got %0d want 1", seq_err_cnt); end
        checks++; if (seq_last !== 16'd6)    begin fails++; $display("[TB] FAIL gap_seq_last got %0d want 6", seq_last); end
        checks++; if (frame_cnt !== 32'd5)   begin fails++; $display("[TB] FAIL gap_frame_cnt got %0d want 5", frame_cnt); end
    endtask

    task automatic test_runt();
        do_reset();
        send_frame(0, 32'h0, 32'h0000_0001, -1);
        checks++; if (out_q.size() !== 0)    begin fails++; $display("[TB] FAIL runt_beats got %0d want 0", out_q.size()); end
        checks++; if (runt_cnt !== 16'd1)    begin fails++; $display("[TB] FAIL runt_cnt got %0d want 1", runt_cnt); end
        checks++; if (frame_cnt !== 32'd1)   begin fails++; $display("[TB] FAIL runt_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (seq_err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL runt_err_cnt got %0d want 0", seq_err_cnt); end
        checks++; if (err_pulses - pulse_base !== 0) begin fails++; $display("[TB] FAIL runt_pulses got %0d want 0", err_pulses - pulse_base); end
    endtask

    task automatic test_wrap();
        do_reset();
        send_frame(1, 32'hB000_0000, 32'h0000_FFFE, -1);
        send_frame(1, 32'hB000_0001, 32'h0000_FFFF, -1);
        send_frame(1, 32'hB000_0002, 32'h0000_0000, -1);
        send_frame(1, 32'hB000_0003, 32'h0000_0001, -1);
        checks++; if (seq_err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL wrap_err_cnt got %0d want 1", seq_err_cnt); end
        checks++; if (err_pulses - pulse_base !== 1) begin fails++; $display("[TB] FAIL wrap_pulses got %0d want 1", err_pulses - pulse_base); end
        checks++; if (seq_last !== 16'd1)    begin fails++; $display("[TB] FAIL wrap_seq_last got %0d want 1", seq_last); end
        checks++; if (frame_cnt !== 32'd4)   begin fails++; $display("[TB] FAIL wrap_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_upper_bits();
        do_reset();
        send_frame(1, 32'hC000_0000, 32'h0000_0001, -1);
        send_frame(1, 32'hC000_0001, 32'h0000_0002, -1);
        send_frame(1, 32'hC000_0002, 32'h0001_0003, -1);
        checks++; if (err_pulses - pulse_base !== 1) begin fails++; $display("[TB] FAIL upper_pulses got %0d want 1", err_pulses - pulse_base); end
        send_frame(1, 32'hC000_0003, 32'h0000_0004, -1);
        checks++; if (seq_err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL upper_err_cnt got %0d want 1", seq_err_cnt); end
        checks++; if (seq_last !== 16'd4)    begin fails++; $display("[TB] FAIL upper_seq_last got %0d want 4", seq_last); end
        checks++; if (frame_cnt !== 32'd4)   begin fails++; $display("[TB] FAIL upper_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        toggle_ready = 1;
        send_frame(5, 32'hE000_0000, 32'h0000_0001, -1);
        send_frame(2, 32'hE100_0000, 32'h0000_0002, -1);
        toggle_ready = 0;
        checks++; if (hs_bad !== 0) begin fails++; $display("[TB] FAIL bp_handshake got %0d want 0", hs_bad); end
        checks++; if (out_q.size() !== 7) begin fails++; $display("[TB] FAIL bp_beats got %0d want 7", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL bp_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (seq_err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL bp_err_cnt got %0d want 0", seq_err_cnt); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        send_frame(3, 32'hF000_0000, 32'h0000_0001, 1);
        tb_strip = 0;
        send_frame(2, 32'hF100_0000, 32'h0000_0002, -1);
        checks++; if (out_q.size() !== 6) begin fails++; $display("[TB] FAIL mode_beats got %0d want 6", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL mode_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (frame_cnt !== 32'd1) begin fails++; $display("[TB] FAIL mode_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (seq_last !== 16'd1)  begin fails++; $display("[TB] FAIL mode_seq_last got %0d want 1", seq_last); end
        checks++; if (hs_bad !== 0) begin fails++; $display("[TB] FAIL mode_handshake got %0d want 0", hs_bad); end
    endtask

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready = 1'b1; ctrl_en = 1'b1;
        test_reset();
        test_basic();
        test_seq_gap();
        test_runt();
        test_wrap();
        test_upper_bits();
        test_backpressure();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seq_strip.md
Name: seq_strip

Overview:
- Receive-side counterpart to the transmit sequence-number appender.
- Sits between the Aurora RX AXI-Stream output and the user/DMA stream.
- Every incoming frame ends with a trailing sequence word {16'h0000, seq}. The block removes that word, moves tlast onto the last payload word, and checks seq continuity.
- Provides error, runt and frame counters for status registers.

Parameters:
- DATA_WIDTH, 32, stream data width.
- SEQ_WIDTH, 16, width of sequence field in bits [SEQ_WIDTH-1:0] of the trailing word.
- SEQ_INIT, 1, expected sequence number of the first frame after reset.

Ports:
- m_axis_aclk  in  1  clock.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tlast  in  1  slave last; marks the sequence word.
- s_axis_tready  out  1  slave ready.
- m_axis_tvalid  out  1  master valid.
- m_axis_tdata  out  DATA_WIDTH  master data.
- m_axis_tlast  out  1  master last.
- m_axis_tready  in  1  master ready.
- ctrl_strip_seq_en  in  1  1 = strip and check; 0 = transparent passthrough.
- seq_last  out  SEQ_WIDTH  last received sequence number.
- seq_err  out  1  one-cycle pulse on sequence mismatch.
- seq_err_cnt  out  16  saturating mismatch count.
- runt_cnt  out  16  saturating count of frames with no payload.
- frame_cnt  out  32  wrapping count of sequence words consumed.

Behaviour:
- Reset (async assert, sync release):
  - hold register empty; in_frame=0; mode_q=1; expected=SEQ_INIT.
  - seq_last=0, seq_err=0, all counters 0.
  - m_axis_tvalid=0; s_axis_tready=1.
- Mode:
  - mode_q loads ctrl_strip_seq_en only when in_frame=0, hold is empty, and no slave beat is accepted that cycle.
  - A mode change mid-frame takes effect at the next frame boundary.
- Passthrough (mode_q=0):
  - m_axis_* = s_axis_* and s_axis_tready = m_axis_tready, combinationally.
  - No checking; counters frozen.
- Strip mode (mode_q=1): one-word hold register (held_data, held_v).
  - s_axis_tready = !held_v | m_axis_tready.
  - m_axis_tvalid = held_v & s_axis_tvalid.
  - m_axis_tdata = held_data.
  - m_axis_tlast = s_axis_tlast.
  - A slave beat is accepted when s_axis_tvalid & s_axis_tready.
  - Accepted non-last beat: if held_v, the held word goes out (tlast=0) in the same cycle. Then held_data <= s_axis_tdata, held_v <= 1, in_frame <= 1.
  - Accepted last beat, held_v=1: held word goes out with tlast=1. The sequence word is consumed, never forwarded. held_v <= 0, in_frame <= 0.
  - Accepted last beat, held_v=0 (runt): nothing is emitted; runt_cnt++. The sequence word is still checked.
  - Latency: a payload word leaves when the next beat arrives. No bubbles are inserted. Full throughput when m_axis_tready=1.
  - Backpressure: with held_v=1 and m_axis_tready=0, s_axis_tready=0 and hold contents stay stable.
- Sequence check (on every consumed sequence word w):
  - Error condition: w[SEQ_WIDTH-1:0] != expected, OR w[DATA_WIDTH-1:SEQ_WIDTH] != 0.
  - On error: seq_err pulses next cycle; seq_err_cnt increments, saturating at 16'hFFFF.
  - Always: seq_last <= w[SEQ_WIDTH-1:0]; expected <= w[SEQ_WIDTH-1:0]+1 modulo 2^SEQ_WIDTH. This resyncs after an error, so a single drop produces exactly one error. 16'hFFFF is followed by expected 16'h0000.
  - frame_cnt++ (wraps).
- All status outputs are registered. A counter increment and a status read in the same cycle are not an issue (registered outputs).

Test Plan:
- Reset, strip on, frame D0,D1,D2,{0,0x0001}(tlast), m_axis_tready=1:
  - Out: D0,D1,D2 with tlast only on D2.
  - seq_last=1, frame_cnt=1, seq_err_cnt=0.
- Frames with seq 1,2,4,5:
  - Exactly one seq_err pulse (at seq 4).
  - seq_err_cnt=1, expected ends at 6.
  - Payloads forwarded intact.
- Runt frame {0,0x0001} alone:
  - No output beat.
  - runt_cnt=1, frame_cnt=1, no error.
- Wrap: frames seq 0xFFFF then 0x0000 (expected forced via prior 0xFFFE frame) -> no errors.
- Sequence word 0x0001_0003 with expected 3 -> seq_err asserted (upper bits nonzero).
- Backpressure:
  - m_axis_tready toggling 1/0 every cycle during a 5-word frame -> s_axis_tready low whenever the hold is full and m_axis_tready=0; payload order and tlast preserved.
  - Asserting ctrl_strip_seq_en=0 mid-frame -> current frame still stripped; next frame passes through unchanged, including its trailing word.
